dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter for the single-port data memory of the RV32I core.
- Port 0 is the core load/store path; port 1 is the program loader/debug path.
- Grants one memory access per cycle through valid/ready handshakes and returns read data with fixed 1-cycle latency.
- Sits between the requesters and the data memory; the core stalls while its req0_ready is low.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high
- req0_valid  input  1  core request valid
- req0_ready  output  1  core request accepted this cycle
- req0_we  input  1  1 = write, 0 = read
- req0_addr  input  ADDR_W  core address
- req0_wdata  input  DATA_W  core write data
- rsp0_valid  output  1  core read data valid
- rsp0_rdata  output  DATA_W  core read data
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata  same as port 0, for the loader
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid 1 cycle after a read strobe

Behaviour:
- Reset values: state=IDLE, last_grant=1 (port 0 wins the first tie), rd_owner=0. All ready, rsp_valid, mem_en and mem_we outputs are 0; mem_addr and mem_wdata are 0.
- Handshake: a requester holds valid, we, addr and wdata stable until ready is seen high. A transfer occurs on a cycle with valid&&ready. At most one ready is high per cycle.
- State IDLE: arbitrate among the asserted valids (combinational).
  - FIXED_PRIO=1: port 0 wins whenever valid.
  - FIXED_PRIO=0: if both are valid, the port != last_grant wins; a single requester always wins.
  - Winner gets ready=1 and mem_en=1 in the same cycle; mem_we, mem_addr and mem_wdata are driven from the winner's inputs.
  - last_grant updates to the winner at the clock edge.
  - Write: stay in IDLE, so back-to-back writes run at 1 per cycle. No response for writes.
  - Read: rd_owner is latched to the winner and state goes to RD_WAIT.
- State RD_WAIT (exactly 1 cycle):
  - rspN_valid=1 for N=rd_owner; rspN_rdata=mem_rdata (combinational pass-through).
  - All ready=0 and mem_en=0; the state returns to IDLE.
  - Read throughput is 1 per 2 cycles.
- rsp_rdata of the non-owning port, and of any port when its rsp_valid=0, is driven to 0.
- No valid asserted in IDLE: mem_en=0, mem_we=0, mem_addr and mem_wdata held at their last values, last_grant unchanged.
- A request that arrives while in RD_WAIT is not lost; it waits with ready=0 and is arbitrated in the next IDLE cycle.
- Starvation bound (round-robin): with both ports continuously valid, each port is granted within 2 grants, i.e. at most 4 cycles.
- Reset mid-read (reset high during RD_WAIT): the pending response is discarded, with no rsp_valid in that or later cycles. The next cycle behaves as reset IDLE.
- An asserted valid is ignored in any cycle with reset high.
- mem_we is 1 only when mem_en is 1.
- Latency: grant and strobe in cycle 0, read data at the requester in cycle 1.

Decomposition:
- Shared package holds:
  - state encoding: ST_IDLE=1'b0, ST_RD_WAIT=1'b1
  - port index constants: PORT_CORE=0, PORT_LDR=1
- One natural sub-module: rr_arb2, a 2-way round-robin/fixed-priority grant with a last_grant register. The FSM, output muxing and response routing stay in dmem_arbiter.

Test Plan:
- Reset and single write: reset 2 cycles, then req0 write addr=0x10, wdata=0xDEADBEEF -> req0_ready=1 and mem_en=1, mem_we=1, mem_addr=0x10 in the same cycle; no rsp0_valid afterwards.
- Single read: req1 read addr=0x20, memory returns 0x12345678 -> cycle0 req1_ready=1, mem_en=1, mem_we=0; cycle1 rsp1_valid=1, rsp1_rdata=0x12345678, rsp0_valid=0.
- Round-robin contention (FIXED_PRIO=0): both ports issue continuous writes -> grants alternate 0,1,0,1 starting with port 0 after reset; 4 writes complete in 4 cycles.
- Fixed priority (FIXED_PRIO=1): both ports valid for 5 cycles of writes -> port 0 is granted all 5 and req1_ready stays 0; port 1 is granted on the first cycle port 0 drops valid.
- Read then contention: port 0 reads 0x40, and port 1 asserts a write during RD_WAIT -> req1_ready=0 in RD_WAIT, rsp0_valid=1 there; port 1 is granted in the next cycle.
- Reset mid-read: port 0 read accepted, reset asserted in the RD_WAIT cycle -> rsp0_valid=0 in all following cycles; after reset, both ports valid -> port 0 is granted first.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared state encoding and port indices for the data memory arbiter
package dmem_arbiter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_RD_WAIT = 1'b1} stateE;
  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_LDR = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin or fixed-priority grant with a last-grant register
module rr_arb2
  import dmem_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic lastGrant;
  // port 0 wins when alone, under fixed priority, or when port 1 had the last turn
  always_comb begin
    gnt[0] = req[0] && (!req[1] || FIXED_PRIO != 0 || lastGrant == PORT_LDR);
    gnt[1] = req[1] && !gnt[0];
  end
  // remember the winner; reset to the loader so the core wins the first tie
  always_ff @(posedge clk) begin
    if (reset) lastGrant <= PORT_LDR;
    else if (|gnt) lastGrant <= gnt[1];
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core and the loader
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  stateE state, stateNext;
  logic rdOwner, anyGnt, win, selWe, rspValid;
  logic [1:0] req, gnt;
  logic [ADDR_W-1:0] selAddr, addrQ;
  logic [DATA_W-1:0] selWdata, wdataQ;
  assign req = {req1_valid, req0_valid} & {2{state == ST_IDLE && !reset}};
  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) uArb (
    .clk(clk),
    .reset(reset),
    .req(req),
    .gnt(gnt)
  );
  // winner mux, next state and response routing
  always_comb begin
    anyGnt = |gnt;
    win = gnt[1];
    selWe = win ? req1_we : req0_we;
    selAddr = win ? req1_addr : req0_addr;
    selWdata = win ? req1_wdata : req0_wdata;
    stateNext = (anyGnt && !selWe) ? ST_RD_WAIT : ST_IDLE;
    req0_ready = gnt[0];
    req1_ready = gnt[1];
    mem_en = anyGnt;
    mem_we = anyGnt && selWe;
    mem_addr = anyGnt ? selAddr : addrQ;
    mem_wdata = anyGnt ? selWdata : wdataQ;
    rspValid = state == ST_RD_WAIT && !reset;
    rsp0_valid = rspValid && rdOwner == PORT_CORE;
    rsp1_valid = rspValid && rdOwner == PORT_LDR;
    rsp0_rdata = rsp0_valid ? mem_rdata : '0;
    rsp1_rdata = rsp1_valid ? mem_rdata : '0;
  end
  // state, read owner and held memory address/data
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      rdOwner <= PORT_CORE;
      addrQ <= '0;
      wdataQ <= '0;
    end else begin
      state <= stateNext;
      if (anyGnt && !selWe) rdOwner <= win;
      if (anyGnt) addrQ <= selAddr;
      if (anyGnt) wdataQ <= selWdata;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for the round-robin and fixed-priority arbiters
module tb_dmem_arbiter;
  logic clk = 0, reset = 1;
  logic req0_valid = 0, req0_we = 0, req1_valid = 0, req1_we = 0;
  logic [31:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
  logic req0Ready, req1Ready, rsp0Valid, rsp1Valid, memEn, memWe;
  logic [31:0] rsp0Rdata, rsp1Rdata, memAddr, memWdata, memRdata;
  logic fReq0Ready, fReq1Ready, fRsp0Valid, fRsp1Valid, fMemEn, fMemWe;
  logic [31:0] fRsp0Rdata, fRsp1Rdata, fMemAddr, fMemWdata;
  logic [31:0] mem [64];
  logic [31:0] refMem [64];
  bit memInit;
  logic [32:0] sb [$];
  int nCmp = 0, nErr = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0Ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0Valid), .rsp0_rdata(rsp0Rdata),
    .req1_valid(req1_valid), .req1_ready(req1Ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1Valid), .rsp1_rdata(rsp1Rdata),
    .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr),
    .mem_wdata(memWdata), .mem_rdata(memRdata)
  );

  dmem_arbiter #(.FIXED_PRIO(1)) dutFix (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(fReq0Ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(fRsp0Valid), .rsp0_rdata(fRsp0Rdata),
    .req1_valid(req1_valid), .req1_ready(fReq1Ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(fRsp1Valid), .rsp1_rdata(fRsp1Rdata),
    .mem_en(fMemEn), .mem_we(fMemWe), .mem_addr(fMemAddr),
    .mem_wdata(fMemWdata), .mem_rdata(memRdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // single-port memory with one-cycle read latency, driven by the round-robin arbiter
  always @(posedge clk) begin
    if (!memInit) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000 + i;
      mem[8] <= 32'h12345678;
      memInit <= 1;
    end else if (memEn) begin
      if (memWe) mem[memAddr[7:2]] <= memWdata;
      else memRdata <= mem[memAddr[7:2]];
    end
  end

  // response monitor: every response must match the oldest expected read
  always @(negedge clk) begin
    logic [32:0] e;
    if (rsp0Valid === 1'b1 || rsp1Valid === 1'b1) begin
      if (sb.size() == 0) chk("rsp_unexpected", {31'b0, rsp1Valid, rsp0Valid}, 32'h0);
      else begin
        e = sb.pop_front();
        chk("rsp_port", {31'b0, rsp1Valid}, {31'b0, e[32]});
        chk("rsp_data", rsp1Valid ? rsp1Rdata : rsp0Rdata, e[31:0]);
        chk("rsp_idle_zero", rsp1Valid ? rsp0Rdata : rsp1Rdata, 32'h0);
      end
    end
  end

  initial begin
    logic [31:0] k0, k1;
    logic expW;
    for (int i = 0; i < 64; i++) refMem[i] = 32'h1000 + i;
    refMem[8] = 32'h12345678;
    req0_valid = 1; req0_we = 1; req0_addr = 32'h4; req0_wdata = 32'h1;
    tick();
    @(negedge clk);
    chk("rst_ready0", {31'b0, req0Ready}, 0);
    chk("rst_mem_en", {31'b0, memEn}, 0);
    chk("rst_mem_addr", memAddr, 0);
    chk("rst_mem_wdata", memWdata, 0);
    chk("rst_rsp0", {31'b0, rsp0Valid}, 0);
    tick();
    reset = 0; req0_addr = 32'h10; req0_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_ready0", {31'b0, req0Ready}, 1);
    chk("wr_mem_en", {31'b0, memEn}, 1);
    chk("wr_mem_we", {31'b0, memWe}, 1);
    chk("wr_mem_addr", memAddr, 32'h10);
    chk("wr_mem_wdata", memWdata, 32'hDEADBEEF);
    tick();
    req0_valid = 0; refMem[4] = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_no_rsp0", {31'b0, rsp0Valid}, 0);
    chk("idle_mem_en", {31'b0, memEn}, 0);
    chk("idle_mem_we", {31'b0, memWe}, 0);
    chk("idle_addr_held", memAddr, 32'h10);
    tick();
    req1_valid = 1; req1_we = 0; req1_addr = 32'h20;
    sb.push_back({1'b1, refMem[8]});
    @(negedge clk);
    chk("rd_ready1", {31'b0, req1Ready}, 1);
    chk("rd_mem_en", {31'b0, memEn}, 1);
    chk("rd_mem_we", {31'b0, memWe}, 0);
    tick();
    req1_valid = 0;
    @(negedge clk);
    chk("rd_rsp1", {31'b0, rsp1Valid}, 1);
    chk("rd_rsp0", {31'b0, rsp0Valid}, 0);
    chk("rd_wait_mem_en", {31'b0, memEn}, 0);
    tick();
    reset = 1;
    tick();
    reset = 0; k0 = 0; k1 = 0;
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1; req0_we = 1; req0_addr = 32'h40 + 4 * k0; req0_wdata = 32'hA0 + k0;
      req1_valid = 1; req1_we = 1; req1_addr = 32'h80 + 4 * k1; req1_wdata = 32'hB0 + k1;
      expW = i[0];
      @(negedge clk);
      chk("rr_gnt0", {31'b0, req0Ready}, {31'b0, !expW});
      chk("rr_gnt1", {31'b0, req1Ready}, {31'b0, expW});
      chk("rr_addr", memAddr, expW ? 32'h80 + 4 * k1 : 32'h40 + 4 * k0);
      tick();
      if (expW) begin refMem[6'(32'h20 + k1)] = 32'hB0 + k1; k1++; end
      else begin refMem[6'(32'h10 + k0)] = 32'hA0 + k0; k0++; end
    end
    req0_addr = 32'hF0; req1_addr = 32'hF4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("fix_gnt0", {31'b0, fReq0Ready}, 1);
      chk("fix_gnt1", {31'b0, fReq1Ready}, 0);
      tick();
    end
    req0_valid = 0;
    @(negedge clk);
    chk("fix_gnt1_free", {31'b0, fReq1Ready}, 1);
    tick();
    req1_valid = 0;
    tick();
    req0_valid = 1; req0_we = 0; req0_addr = 32'h40;
    sb.push_back({1'b0, refMem[16]});
    @(negedge clk);
    chk("rc_ready0", {31'b0, req0Ready}, 1);
    tick();
    req0_valid = 0;
    req1_valid = 1; req1_we = 1; req1_addr = 32'hC0; req1_wdata = 32'h55;
    @(negedge clk);
    chk("rc_wait_ready1", {31'b0, req1Ready}, 0);
    chk("rc_rsp0", {31'b0, rsp0Valid}, 1);
    tick();
    @(negedge clk);
    chk("rc_late_ready1", {31'b0, req1Ready}, 1);
    chk("rc_late_addr", memAddr, 32'hC0);
    tick();
    refMem[48] = 32'h55;
    req1_we = 0;
    sb.push_back({1'b1, refMem[48]});
    @(negedge clk);
    chk("rb_ready1", {31'b0, req1Ready}, 1);
    tick();
    req1_valid = 0;
    @(negedge clk);
    chk("rb_rsp1", {31'b0, rsp1Valid}, 1);
    tick();
    req0_valid = 1; req0_we = 0; req0_addr = 32'h44;
    @(negedge clk);
    chk("mr_ready0", {31'b0, req0Ready}, 1);
    tick();
    req0_valid = 0; reset = 1;
    @(negedge clk);
    chk("mr_rsp0_rst", {31'b0, rsp0Valid}, 0);
    tick();
    reset = 0;
    req0_valid = 1; req0_we = 1; req0_addr = 32'hE0;
    req1_valid = 1; req1_we = 1; req1_addr = 32'hE4;
    @(negedge clk);
    chk("mr_rsp0_after", {31'b0, rsp0Valid}, 0);
    chk("mr_gnt0", {31'b0, req0Ready}, 1);
    chk("mr_gnt1", {31'b0, req1Ready}, 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    repeat (3) tick();
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
